product_bcd_converter: RTL and testbench



---
 rtl/product_bcd_converter_pkg.sv | 46 ++++
 rtl/product_bcd_converter_bcd_add3.sv | 16 +
 rtl/product_bcd_converter.sv | 119 +++++++++++
 tb/tb_product_bcd_converter.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/product_bcd_converter_pkg.sv
// Shared types and constants for the signed product to BCD converter.
// Segment helpers are only referenced when PRODUCT_BCD_SEG7_EN is defined.
package product_bcd_converter_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StShift = 2'd1,
    StDone  = 2'd2
  } state_e;

  localparam int unsigned DigitW    = 4;
  localparam int unsigned IterCount = 8;

  // Active-high {g,f,e,d,c,b,a}
  localparam logic [6:0] Seg0     = 7'h3F;
  localparam logic [6:0] Seg1     = 7'h06;
  localparam logic [6:0] Seg2     = 7'h5B;
  localparam logic [6:0] Seg3     = 7'h4F;
  localparam logic [6:0] Seg4     = 7'h66;
  localparam logic [6:0] Seg5     = 7'h6D;
  localparam logic [6:0] Seg6     = 7'h7D;
  localparam logic [6:0] Seg7     = 7'h07;
  localparam logic [6:0] Seg8     = 7'h7F;
  localparam logic [6:0] Seg9     = 7'h6F;
  localparam logic [6:0] SegMinus = 7'h40;
  localparam logic [6:0] SegBlank = 7'h00;

  function automatic logic [6:0] seg7_decode(input logic [DigitW-1:0] digit);
    logic [6:0] seg;
    case (digit)
      4'd0:    seg = Seg0;
      4'd1:    seg = Seg1;
      4'd2:    seg = Seg2;
      4'd3:    seg = Seg3;
      4'd4:    seg = Seg4;
      4'd5:    seg = Seg5;
      4'd6:    seg = Seg6;
      4'd7:    seg = Seg7;
      4'd8:    seg = Seg8;
      4'd9:    seg = Seg9;
      default: seg = SegBlank;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/product_bcd_converter_bcd_add3.sv
// Double-dabble digit correction: adds 3 to a BCD digit that is 5 or more.
module product_bcd_converter_bcd_add3
  import product_bcd_converter_pkg::*;
(
  input  logic [DigitW-1:0] din,
  output logic [DigitW-1:0] dout
);

  always_comb begin
    dout = din;
    if (din >= 4'd5) begin
      dout = din + 4'd3;
    end
  end

endmodule

// File: rtl/product_bcd_converter.sv
// Sequential signed 8-bit to sign + 3-digit BCD converter (shift-and-add-3).
// Define PRODUCT_BCD_SEG7_EN to add registered 7-segment outputs.
module product_bcd_converter
  import product_bcd_converter_pkg::*;
(
  input  logic       Clk,
  input  logic       Reset,
  input  logic       Start,
  input  logic [7:0] P,
  output logic       Busy,
  output logic       Done,
  output logic       Neg,
  output logic [3:0] Hundreds,
  output logic [3:0] Tens,
`ifdef PRODUCT_BCD_SEG7_EN
  output logic [3:0] Ones,
  output logic [6:0] Seg_Sign,
  output logic [6:0] Seg_H,
  output logic [6:0] Seg_T,
  output logic [6:0] Seg_O
`else
  output logic [3:0] Ones
`endif
);

  state_e      state_q, state_d;
  logic [7:0]  mag_q, mag_d;
  logic [11:0] scratch_q, scratch_d;
  logic [11:0] scratch_adj;
  logic [2:0]  cnt_q, cnt_d;
  logic        neg_cap_q, neg_cap_d;
  logic        load;

  for (genvar i = 0; i < 3; i++) begin : g_add3
    product_bcd_converter_bcd_add3 u_add3 (
      .din  (scratch_q[i*DigitW +: DigitW]),
      .dout (scratch_adj[i*DigitW +: DigitW])
    );
  end

  always_comb begin
    state_d   = state_q;
    mag_d     = mag_q;
    scratch_d = scratch_q;
    cnt_d     = cnt_q;
    neg_cap_d = neg_cap_q;
    load      = 1'b0;
    case (state_q)
      StIdle: begin
        if (Start) begin
          // 8-bit negate of -128 yields 8'h80, which is the correct magnitude.
          mag_d     = P[7] ? 8'(-P) : P;
          neg_cap_d = P[7];
          scratch_d = '0;
          cnt_d     = '0;
          state_d   = StShift;
        end
      end
      StShift: begin
        {scratch_d, mag_d} = {scratch_adj, mag_q} << 1;
        cnt_d = cnt_q + 3'd1;
        if (cnt_q == 3'(IterCount - 1)) begin
          state_d = StDone;
          load    = 1'b1;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q   <= StIdle;
      mag_q     <= '0;
      scratch_q <= '0;
      cnt_q     <= '0;
      neg_cap_q <= 1'b0;
      Busy      <= 1'b0;
      Done      <= 1'b0;
      Neg       <= 1'b0;
      Hundreds  <= '0;
      Tens      <= '0;
      Ones      <= '0;
    end else begin
      state_q   <= state_d;
      mag_q     <= mag_d;
      scratch_q <= scratch_d;
      cnt_q     <= cnt_d;
      neg_cap_q <= neg_cap_d;
      Busy      <= (state_d == StShift);
      Done      <= (state_d == StDone);
      // Results are loaded on the edge that enters DONE so they are valid with Done.
      if (load) begin
        Neg      <= neg_cap_q;
        Hundreds <= scratch_d[11:8];
        Tens     <= scratch_d[7:4];
        Ones     <= scratch_d[3:0];
      end
    end
  end

`ifdef PRODUCT_BCD_SEG7_EN
  always_ff @(posedge Clk) begin
    if (Reset) begin
      Seg_Sign <= SegBlank;
      Seg_H    <= SegBlank;
      Seg_T    <= SegBlank;
      Seg_O    <= SegBlank;
    end else if (load) begin
      Seg_Sign <= neg_cap_q ? SegMinus : SegBlank;
      Seg_H    <= (scratch_d[11:8] == 4'd0) ? SegBlank : seg7_decode(scratch_d[11:8]);
      Seg_T    <= (scratch_d[11:4] == 8'd0) ? SegBlank : seg7_decode(scratch_d[7:4]);
      Seg_O    <= seg7_decode(scratch_d[3:0]);
    end
  end
`endif

endmodule

// File: tb/tb_product_bcd_converter.sv
// Directed scoreboard bench for product_bcd_converter.
module tb_product_bcd_converter;

  logic       Clk = 1'b0;
  logic       Reset, Start;
  logic [7:0] P;
  logic       Busy, Done, Neg;
  logic [3:0] Hundreds, Tens, Ones;
`ifdef PRODUCT_BCD_SEG7_EN
  logic [6:0] Seg_Sign, Seg_H, Seg_T, Seg_O;
`endif

  int checks   = 0;
  int failures = 0;

  typedef struct packed {
    logic       neg;
    logic [3:0] h;
    logic [3:0] t;
    logic [3:0] o;
  } exp_t;

  exp_t exp_q[$];
  exp_t last_exp;

  product_bcd_converter dut (
    .Clk      (Clk),
    .Reset    (Reset),
    .Start    (Start),
    .P        (P),
    .Busy     (Busy),
    .Done     (Done),
    .Neg      (Neg),
    .Hundreds (Hundreds),
    .Tens     (Tens),
`ifdef PRODUCT_BCD_SEG7_EN
    .Ones     (Ones),
    .Seg_Sign (Seg_Sign),
    .Seg_H    (Seg_H),
    .Seg_T    (Seg_T),
    .Seg_O    (Seg_O)
`else
    .Ones     (Ones)
`endif
  );

  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic exp_t model(input logic [7:0] p);
    int v;
    exp_t e;
    v = $signed(p);
    e.neg = (v < 0);
    if (v < 0) v = -v;
    e.h = 4'(v / 100);
    e.t = 4'((v / 10) % 10);
    e.o = 4'(v % 10);
    return e;
  endfunction

`ifdef PRODUCT_BCD_SEG7_EN
  function automatic logic [6:0] seg_ref(input logic [3:0] d);
    logic [6:0] tbl [10];
    tbl = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};
    return tbl[d];
  endfunction
`endif

  // Scoreboard: every Done pops one expected result.
  always @(negedge Clk) begin
    if (Busy && Done) check("busy_done_overlap", 1, 0);
    if (Done) begin
      if (exp_q.size() == 0) begin
        check("unexpected_done", 1, 0);
      end else begin
        last_exp = exp_q.pop_front();
        check("neg", Neg, last_exp.neg);
        check("hundreds", Hundreds, last_exp.h);
        check("tens", Tens, last_exp.t);
        check("ones", Ones, last_exp.o);
`ifdef PRODUCT_BCD_SEG7_EN
        check("seg_sign", Seg_Sign, last_exp.neg ? 7'h40 : 7'h00);
        check("seg_h", Seg_H, (last_exp.h == 0) ? 7'h00 : seg_ref(last_exp.h));
        check("seg_t", Seg_T, (last_exp.h == 0 && last_exp.t == 0) ? 7'h00
                              : seg_ref(last_exp.t));
        check("seg_o", Seg_O, seg_ref(last_exp.o));
`endif
      end
    end
  end

  task automatic pulse_start(input logic [7:0] p, input bit accepted);
    @(negedge Clk);
    P     = p;
    Start = 1'b1;
    if (accepted) exp_q.push_back(model(p));
    @(negedge Clk);
    Start = 1'b0;
    P     = 8'hA5;
  endtask

  // Start, then measure Busy cycles and Done latency (first negedge after edge N is k=1).
  task automatic convert(input logic [7:0] p, input int ignored_at);
    int nbusy = 0;
    int done_k = 0;
    @(negedge Clk);
    P     = p;
    Start = 1'b1;
    exp_q.push_back(model(p));
    for (int k = 1; k <= 20; k++) begin
      @(negedge Clk);
      Start = 1'b0;
      P     = 8'h5A;
      if (k == ignored_at) begin
        P     = 8'hC8;
        Start = 1'b1;
      end
      if (Busy) nbusy++;
      if (Done) begin
        done_k = k;
        break;
      end
    end
    Start = 1'b0;
    check("busy_cycles", nbusy, 8);
    check("done_latency", done_k, 9);
  endtask

  initial begin
    Reset = 1'b1;
    Start = 1'b0;
    P     = 8'h00;
    repeat (3) @(negedge Clk);
    check("rst_busy", Busy, 0);
    check("rst_done", Done, 0);
    check("rst_digits", {Neg, Hundreds, Tens, Ones}, 13'h0);
    Reset = 1'b0;

    convert(8'h40, 0);
    convert(8'hC8, 0);
    convert(8'h80, 0);
    convert(8'h7F, 0);
    convert(8'h00, 0);

    // Start during Busy is ignored; one Done and outputs hold afterwards.
    convert(8'h40, 3);
    repeat (12) @(negedge Clk);
    check("hold_digits", {Neg, Hundreds, Tens, Ones}, {1'b0, 12'h064});
    check("queue_empty", exp_q.size(), 0);

    // Reset on the 4th SHIFT cycle of -128 discards the conversion.
    @(negedge Clk);
    P     = 8'h80;
    Start = 1'b1;
    @(negedge Clk);
    Start = 1'b0;
    repeat (3) @(negedge Clk);
    Reset = 1'b1;
    @(negedge Clk);
    check("midrst_busy", Busy, 0);
    check("midrst_done", Done, 0);
    check("midrst_digits", {Neg, Hundreds, Tens, Ones}, 13'h0);
    Reset = 1'b0;
    repeat (12) @(negedge Clk);
    check("midrst_no_done_digits", {Neg, Hundreds, Tens, Ones}, 13'h0);
    convert(8'h09, 0);

    // P changes after capture must not affect the result.
    pulse_start(8'hE7, 1'b1);
    repeat (12) @(negedge Clk);
    check("final_queue_empty", exp_q.size(), 0);
    check("capture_digits", {Neg, Hundreds, Tens, Ones}, {1'b1, 12'h025});

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
